// File: rtl/ram_arbiter_pkg.sv
// Shared constants and the round-robin pick for the two-master RAM arbiter.
package ram_arbiter_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    // Returns the winning master index (0 or 1); on a tie the master that did not win last time goes.
    function automatic logic rr_pick(input logic req0, input logic req1, input logic last);
        return (req0 && req1) ? ~last : req1;
    endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two masters and the arbiter; slave is the arbiter side.
interface ram_arbiter_if
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();
    // Handshake: a master holds req/wr/addr/wdata stable until its one-cycle ack;
    // rdata is valid while the owner's ack is high; req high again after ack is a new request.
    logic              m0_req;
    logic              m0_wr;
    logic [ADDR_W-1:0] m0_addr;
    logic [DATA_W-1:0] m0_wdata;
    logic              m0_ack;
    logic              m1_req;
    logic              m1_wr;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_wdata;
    logic              m1_ack;
    logic [DATA_W-1:0] rdata;
    logic              busy;
    logic [1:0]        dbg_state;

    modport slave (
        input  m0_req, m0_wr, m0_addr, m0_wdata,
        input  m1_req, m1_wr, m1_addr, m1_wdata,
        output m0_ack, m1_ack, rdata, busy, dbg_state
    );

    modport master (
        output m0_req, m0_wr, m0_addr, m0_wdata,
        output m1_req, m1_wr, m1_addr, m1_wdata,
        input  m0_ack, m1_ack, rdata, busy, dbg_state
    );
endinterface

// File: rtl/ram_arbiter_ram.sv
// Single-port RAM: synchronous write, combinational read, contents not reset.
module ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              wr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] r_mem [0:(2**ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (wr) begin
            r_mem[addr] <= wdata;
        end
    end

    assign rdata = r_mem[addr];
endmodule

// File: rtl/ram_arbiter.sv
// Round-robin arbiter serialising two masters into fixed three-cycle accesses to one owned RAM.
module ram_arbiter
    import ram_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic          clk,
    input  logic          reset,
    ram_arbiter_if.slave  bus
);
    logic [1:0]        r_state;
    logic              r_owner;
    logic              r_last;
    logic              r_wr;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              r_m0_ack;
    logic              r_m1_ack;

    logic              w_any_req;
    logic              w_grant;
    logic              w_ram_wr;
    logic [DATA_W-1:0] w_ram_rdata;

    assign w_any_req = bus.m0_req | bus.m1_req;
    assign w_grant   = rr_pick(bus.m0_req, bus.m1_req, r_last);
    // Gated by reset as well so a reset landing in ACCESS can never commit a write.
    assign w_ram_wr  = (r_state == ST_ACCESS) && r_wr && !reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_owner  <= 1'b0;
            r_last   <= 1'b1;
            r_wr     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata  <= '0;
            r_m0_ack <= 1'b0;
            r_m1_ack <= 1'b0;
        end else begin
            r_m0_ack <= 1'b0;
            r_m1_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any_req) begin
                        r_owner <= w_grant;
                        r_wr    <= w_grant ? bus.m1_wr    : bus.m0_wr;
                        r_addr  <= w_grant ? bus.m1_addr  : bus.m0_addr;
                        r_wdata <= w_grant ? bus.m1_wdata : bus.m0_wdata;
                        r_state <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!r_wr) begin
                        r_rdata <= w_ram_rdata;
                    end
                    r_last   <= r_owner;
                    r_m0_ack <= ~r_owner;
                    r_m1_ack <= r_owner;
                    r_state  <= ST_DONE;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_ram (
        .clk   (clk),
        .addr  (r_addr),
        .wdata (r_wdata),
        .wr    (w_ram_wr),
        .rdata (w_ram_rdata)
    );

    assign bus.m0_ack    = r_m0_ack;
    assign bus.m1_ack    = r_m1_ack;
    assign bus.rdata     = r_rdata;
    assign bus.busy      = (r_state != ST_IDLE);
    assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: table of single accesses plus tie, lone-requester, reset and DONE-pulse sequences.
module tb_ram_arbiter;
    import ram_arbiter_pkg::*;

    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int SBW = DW + 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    ram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    // Scoreboard entry: {master, is_read, expected read data}
    logic [SBW-1:0] exp_q [$];

    typedef struct packed {
        logic          m;
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } vec_t;
    vec_t vecs [0:5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [SBW-1:0] e;
        if (!reset && (bus.m0_ack || bus.m1_ack)) begin
            if (bus.m0_ack && bus.m1_ack) check("dual_ack", 1, 0);
            if (exp_q.size() == 0) begin
                check("unexpected_ack", {30'd0, bus.m1_ack, bus.m0_ack}, 0);
            end else begin
                e = exp_q.pop_front();
                check("ack_owner", {31'd0, bus.m1_ack}, {31'd0, e[SBW-1]});
                if (e[SBW-2]) check("rdata", {24'd0, bus.rdata}, {24'd0, e[DW-1:0]});
            end
        end
    end

    task automatic drive(input logic m, input logic req, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (!m) begin
            bus.m0_req = req; bus.m0_wr = wr; bus.m0_addr = a; bus.m0_wdata = d;
        end else begin
            bus.m1_req = req; bus.m1_wr = wr; bus.m1_addr = a; bus.m1_wdata = d;
        end
    endtask

    function automatic logic ack_of(input logic m);
        return m ? bus.m1_ack : bus.m0_ack;
    endfunction

    task automatic push_exp(input logic m, input logic wr, input logic [DW-1:0] exp);
        exp_q.push_back({m, ~wr, exp});
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_m0_ack", {31'd0, bus.m0_ack}, 0);
        check("rst_m1_ack", {31'd0, bus.m1_ack}, 0);
        check("rst_rdata", {24'd0, bus.rdata}, 0);
        check("rst_busy", {31'd0, bus.busy}, 0);
        check("rst_state", {30'd0, bus.dbg_state}, {30'd0, ST_IDLE});
        reset = 1'b0;
    endtask

    task automatic single(input logic m, input logic wr, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input logic [DW-1:0] exp);
        int cyc;
        int n_busy;
        push_exp(m, wr, exp);
        @(negedge clk);
        drive(m, 1'b1, wr, a, d);
        cyc = 0;
        n_busy = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (bus.busy) n_busy++;
        end while (!ack_of(m) && cyc < 20);
        check("latency", cyc, 2);
        check("busy_cycles", n_busy, 2);
        drive(m, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        check("idle_after", {31'd0, bus.busy}, 0);
    endtask

    // Holds requests and records the cycle of each ack relative to the drive point.
    task automatic run_held(input int n_acks, input logic both);
        int cyc;
        int n;
        int t [0:7];
        cyc = 0;
        n = 0;
        while (n < n_acks && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (bus.m0_ack || bus.m1_ack) begin
                t[n] = cyc;
                n++;
                if (n == n_acks) begin
                    drive(1'b0, 1'b0, 1'b0, '0, '0);
                    drive(1'b1, 1'b0, 1'b0, '0, '0);
                end
            end
        end
        check(both ? "tie_ack_count" : "lone_ack_count", n, n_acks);
        for (int k = 0; k < n; k++) begin
            check(both ? "tie_ack_time" : "lone_ack_time", t[k], 2 + 3 * k);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int cyc;
        int n_m0;
        bus.m0_req = 1'b0; bus.m0_wr = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_wr = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;

        vecs[0] = '{m: 1'b0, wr: 1'b1, addr: 8'd1, wdata: 8'h55, exp: 8'h00};
        vecs[1] = '{m: 1'b1, wr: 1'b0, addr: 8'd1, wdata: 8'h00, exp: 8'h55};
        vecs[2] = '{m: 1'b0, wr: 1'b1, addr: 8'd2, wdata: 8'h56, exp: 8'h00};
        vecs[3] = '{m: 1'b1, wr: 1'b1, addr: 8'd4, wdata: 8'h11, exp: 8'h00};
        vecs[4] = '{m: 1'b0, wr: 1'b0, addr: 8'd4, wdata: 8'h00, exp: 8'h11};
        vecs[5] = '{m: 1'b1, wr: 1'b0, addr: 8'd2, wdata: 8'h00, exp: 8'h56};

        do_reset();
        for (int i = 0; i < 6; i++) begin
            single(vecs[i].m, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
            if (i == 2) check("rdata_hold", {24'd0, bus.rdata}, 32'h55);
        end

        // Both masters from reset: alternate m0, m1, m0, m1.
        do_reset();
        push_exp(1'b0, 1'b0, 8'h56);
        push_exp(1'b1, 1'b1, 8'h00);
        push_exp(1'b0, 1'b0, 8'h56);
        push_exp(1'b1, 1'b1, 8'h00);
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b0, 8'd2, 8'h00);
        drive(1'b1, 1'b1, 1'b1, 8'd3, 8'hA5);
        run_held(4, 1'b1);

        // m1 alone after m1 won last: never blocked by the pointer.
        for (int k = 0; k < 3; k++) push_exp(1'b1, 1'b0, 8'hA5);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b0, 8'd3, 8'h00);
        run_held(3, 1'b0);

        // Reset during ACCESS of a write: nothing commits, no ack.
        @(negedge clk);
        drive(1'b0, 1'b1, 1'b1, 8'd4, 8'hFF);
        @(negedge clk);
        check("mid_state", {30'd0, bus.dbg_state}, {30'd0, ST_ACCESS});
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        #1;
        check("mid_busy", {31'd0, bus.busy}, 0);
        check("mid_rdata", {24'd0, bus.rdata}, 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        single(1'b1, 1'b0, 8'd4, 8'h00, 8'h11);

        // m0 req pulsed only while in DONE is ignored.
        push_exp(1'b1, 1'b1, 8'h00);
        @(negedge clk);
        drive(1'b1, 1'b1, 1'b1, 8'd5, 8'h77);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.m1_ack && cyc < 20);
        check("done_latency", cyc, 2);
        check("done_state", {30'd0, bus.dbg_state}, {30'd0, ST_DONE});
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        drive(1'b0, 1'b1, 1'b0, 8'd5, 8'h00);
        @(negedge clk);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        n_m0 = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.m0_ack) n_m0++;
        end
        check("done_pulse_ignored", n_m0, 0);
        single(1'b0, 1'b0, 8'd5, 8'h00, 8'h77);

        check("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
